// File: rtl/mega_rom_arbiter.sv
// Shares one registered-read program ROM between instruction fetch and LPM byte reads; LPM has priority.
// Optional fetch starvation guard: define MEGA_ROM_ARB_STARVE_GUARD_EN to build it.
module mega_rom_arbiter #(
  parameter int ADDR_ROM_BUS_WIDTH = 14,
  parameter int STARVE_LIMIT       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_req,
  input  logic [ADDR_ROM_BUS_WIDTH-1:0] fetch_addr,
  output logic                          fetch_gnt,
  output logic                          fetch_valid,
  output logic [15:0]                   fetch_data,
  input  logic                          lpm_req,
  input  logic [ADDR_ROM_BUS_WIDTH:0]   lpm_addr,
  output logic                          lpm_gnt,
  output logic                          lpm_valid,
  output logic [7:0]                    lpm_data,
  output logic [ADDR_ROM_BUS_WIDTH-1:0] rom_a,
  input  logic [15:0]                   rom_d
);

  localparam int AW = ADDR_ROM_BUS_WIDTH;

  logic          r_fetch_valid;
  logic          r_lpm_valid;
  logic          r_byte_sel;
  logic [AW-1:0] r_held_addr;
  logic          w_fetch_force;
  logic          w_fetch_gnt;
  logic          w_lpm_gnt;

`ifdef MEGA_ROM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starve_cnt;

  // Once fetch has been refused STARVE_LIMIT cycles in a row it wins the next arbitration.
  assign w_fetch_force = (r_starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!fetch_req || w_fetch_gnt) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end
`else
  logic w_unused_starve_limit;

  assign w_unused_starve_limit = (STARVE_LIMIT > 0);
  assign w_fetch_force         = 1'b0;
`endif

  // Grants are combinational and suppressed while reset is asserted so nothing issues during reset.
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_lpm_gnt   = 1'b0;
    if (rst_n) begin
      w_fetch_gnt = fetch_req && (!lpm_req || w_fetch_force);
      w_lpm_gnt   = lpm_req && !w_fetch_gnt;
    end
  end

  always_comb begin
    rom_a = '0;
    if (rst_n) begin
      if (w_fetch_gnt) begin
        rom_a = fetch_addr;
      end else if (w_lpm_gnt) begin
        rom_a = lpm_addr[AW:1];
      end else begin
        rom_a = r_held_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_lpm_valid   <= 1'b0;
      r_held_addr   <= '0;
      r_byte_sel    <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_gnt;
      r_lpm_valid   <= w_lpm_gnt;
      if (w_fetch_gnt || w_lpm_gnt) begin
        r_held_addr <= rom_a;
      end
      if (w_lpm_gnt) begin
        r_byte_sel <= lpm_addr[0];
      end
    end
  end

  // Read data comes straight from the ROM's output register, aligned with the valid pulse.
  assign fetch_gnt   = w_fetch_gnt;
  assign lpm_gnt     = w_lpm_gnt;
  assign fetch_valid = r_fetch_valid;
  assign lpm_valid   = r_lpm_valid;
  assign fetch_data  = rom_d;
  assign lpm_data    = r_byte_sel ? rom_d[15:8] : rom_d[7:0];

endmodule

// File: tb/tb_mega_rom_arbiter.sv
// Directed scoreboard bench for mega_rom_arbiter with a behavioural registered-read ROM.
// Expected grant patterns follow MEGA_ROM_ARB_STARVE_GUARD_EN when it is defined.
module tb_mega_rom_arbiter;

  localparam int AW = 14;

  logic          clk;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [15:0]   fetch_data;
  logic          lpm_req;
  logic [AW:0]   lpm_addr;
  logic          lpm_gnt;
  logic          lpm_valid;
  logic [7:0]    lpm_data;
  logic [AW-1:0] rom_a;
  logic [15:0]   rom_d;

  logic [15:0]   mem [0:(1<<AW)-1];

  typedef struct {
    bit          is_lpm;
    logic [15:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] held_model;
  int            n_cmp;
  int            n_fail;
  bit            guard_on;

  mega_rom_arbiter #(.ADDR_ROM_BUS_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .lpm_req    (lpm_req),
    .lpm_addr   (lpm_addr),
    .lpm_gnt    (lpm_gnt),
    .lpm_valid  (lpm_valid),
    .lpm_data   (lpm_data),
    .rom_a      (rom_a),
    .rom_d      (rom_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_d <= mem[rom_a];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_valids(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, !e.is_lpm});
      check({tag, ".lpm_valid"}, {31'd0, lpm_valid}, {31'd0, e.is_lpm});
      if (e.is_lpm) check({tag, ".lpm_data"}, {24'd0, lpm_data}, {16'd0, e.data});
      else          check({tag, ".fetch_data"}, {16'd0, fetch_data}, {16'd0, e.data});
    end else begin
      check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
      check({tag, ".lpm_valid"}, {31'd0, lpm_valid}, 32'd0);
    end
  endtask

  // One arbitration cycle: drive at negedge, check grants/rom_a, then check the follow-up valid.
  task automatic step(input string tag, input logic freq, input logic [AW-1:0] fa,
                      input logic lreq, input logic [AW:0] la, input logic efg, input logic elg);
    exp_t          e;
    logic [AW-1:0] exp_a;
    logic [15:0]   w;
    @(negedge clk);
    fetch_req  = freq;
    fetch_addr = fa;
    lpm_req    = lreq;
    lpm_addr   = la;
    #1;
    exp_a = efg ? fa : (elg ? la[AW:1] : held_model);
    check({tag, ".fetch_gnt"}, {31'd0, fetch_gnt}, {31'd0, efg});
    check({tag, ".lpm_gnt"}, {31'd0, lpm_gnt}, {31'd0, elg});
    check({tag, ".rom_a"}, {18'd0, rom_a}, {18'd0, exp_a});
    $display("txn %-10s freq=%0b fa=%04h lreq=%0b la=%05h -> fgnt=%0b lgnt=%0b rom_a=%04h",
             tag, freq, fa, lreq, la, fetch_gnt, lpm_gnt, rom_a);
    if (efg) begin
      held_model = fa;
      e.is_lpm = 1'b0;
      e.data   = mem[fa];
      sb.push_back(e);
    end else if (elg) begin
      held_model = la[AW:1];
      w = mem[la[AW:1]];
      e.is_lpm = 1'b1;
      e.data   = la[0] ? {8'd0, w[15:8]} : {8'd0, w[7:0]};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check_valids(tag);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    held_model = '0;
`ifdef MEGA_ROM_ARB_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i) * 16'h9E37 ^ 16'hA5C3;
    mem[16'h0010] = 16'hABCD;

    // Requests held high during reset must not be granted.
    rst_n      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 14'h0123;
    lpm_req    = 1'b1;
    lpm_addr   = 15'h0457;
    #3;
    check("rst.fetch_gnt", {31'd0, fetch_gnt}, 32'd0);
    check("rst.lpm_gnt", {31'd0, lpm_gnt}, 32'd0);
    check("rst.rom_a", {18'd0, rom_a}, 32'd0);
    check("rst.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst.lpm_valid", {31'd0, lpm_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    fetch_req = 1'b0;
    lpm_req   = 1'b0;

    step("idle0", 1'b0, 14'h0000, 1'b0, 15'h0000, 1'b0, 1'b0);
    step("fetch10", 1'b1, 14'h0010, 1'b0, 15'h0000, 1'b1, 1'b0);
    step("lpm21", 1'b0, 14'h0000, 1'b1, 15'h0021, 1'b0, 1'b1);
    step("lpm20", 1'b0, 14'h0000, 1'b1, 15'h0020, 1'b0, 1'b1);
    step("idle1", 1'b0, 14'h0000, 1'b0, 15'h0000, 1'b0, 1'b0);
    step("both", 1'b1, 14'h0011, 1'b1, 15'h0081, 1'b0, 1'b1);
    step("lpmdrop", 1'b1, 14'h0011, 1'b0, 15'h0000, 1'b1, 1'b0);

    for (int k = 0; k < 4; k++)
      step($sformatf("seq%0d", k), 1'b1, 14'(k), 1'b0, 15'h0000, 1'b1, 1'b0);

    // Both requests held: guard grants fetch on the fifth cycle, strict priority never does.
    for (int k = 0; k < 7; k++)
      step($sformatf("starve%0d", k), 1'b1, 14'h0222, 1'b1, 15'h0667,
           guard_on && (k == 4), !(guard_on && (k == 4)));

    // Reset pulsed while a fetch valid is high: valid must drop at once and never reappear.
    step("prerst", 1'b1, 14'h0005, 1'b0, 15'h0000, 1'b1, 1'b0);
    @(negedge clk);
    check("midrst.fetch_valid_before", {31'd0, fetch_valid}, 32'd1);
    rst_n     = 1'b0;
    fetch_req = 1'b1;
    lpm_req   = 1'b1;
    lpm_addr  = 15'h0033;
    #1;
    check("midrst.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("midrst.fetch_gnt", {31'd0, fetch_gnt}, 32'd0);
    check("midrst.lpm_gnt", {31'd0, lpm_gnt}, 32'd0);
    check("midrst.rom_a", {18'd0, rom_a}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst.lpm_valid", {31'd0, lpm_valid}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    fetch_req  = 1'b0;
    lpm_req    = 1'b0;
    held_model = '0;
    step("postrst", 1'b0, 14'h0000, 1'b0, 15'h0000, 1'b0, 1'b0);
    step("resume", 1'b1, 14'h0007, 1'b0, 15'h0000, 1'b1, 1'b0);
    step("tail", 1'b0, 14'h0000, 1'b0, 15'h0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
